ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have `clk  in  1`: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have `reset  in  1`: reset is synchronous and active-high.
REQ-003 SHALL have inputs from the decode stage:
- `pc_in  in  32`: PC of the instruction in EX.
- `iw_in  in  32`: instruction word; 0x00000013 marks a flushed bubble.
- `wb_reg_in  in  5`: destination register.
- `wb_enable_in  in  1`: destination write request.
- `mem_we_in  in  1`: store flag.
- `rs1_data_in  in  32` and `rs2_data_in  in  32`: forwarded operands.
- `ebreak_in  in  1`: EBREAK flag.
REQ-004 SHALL have forwarding outputs to decode, all combinational:
- `df_ex_enable  out  1`
- `df_ex_reg  out  5`
- `df_ex_data  out  32`
REQ-005 SHALL have registered outputs to the memory stage:
- `pc_out  out  32`, `iw_out  out  32`
- `wb_reg_out  out  5`, `wb_enable_out  out  1`
- `mem_we_out  out  1`
- `alu_result_out  out  32`: ALU result or effective address.
- `store_data_out  out  32`: rs2 data.
- `ebreak_out  out  1`

Function
REQ-006 SHALL decode `iw_in[6:0]` and compute the result combinationally:
- LUI: {iw[31:12], 12'b0}.
- AUIPC: pc_in + {iw[31:12], 12'b0}.
- JAL/JALR: pc_in + 4.
- LOAD: rs1 + sext(iw[31:20]).
- STORE: rs1 + sext({iw[31:25], iw[11:7]}).
- BRANCH/SYSTEM/unknown opcode: 0.
REQ-007 SHALL implement OP-IMM with the I-immediate and OP with rs2 for ADD, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND:
- OP with iw[30]=1 SHALL select SUB.
- SRAI/SRA SHALL be selected by iw[30].
- Shift amount SHALL be operand[4:0]; 32-bit wraparound, no overflow flag.
- SLT/SLTU SHALL return 32'h1 or 32'h0.
REQ-008 SHALL drive:
- `df_ex_data` = the same-cycle result.
- `df_ex_reg` = `wb_reg_in`.
- `df_ex_enable` = `wb_enable_in` AND `wb_reg_in`≠0 AND opcode≠LOAD AND NOT halted.
REQ-009 SHALL register every output on each rising clock edge: 1-cycle latency, no stall, no back-pressure.
REQ-010 SHALL force `wb_enable_out`=0 whenever `wb_reg_in`=0; x0 is never written.
REQ-011 SHALL keep a `halted` flag:
- Set on the edge where `ebreak_in`=1.
- Cleared only by reset.
- `ebreak_out` SHALL equal `halted` (sticky).
REQ-012 While `halted`=1, every incoming instruction SHALL leave EX as a bubble:
- `iw_out`=0x00000013.
- `wb_enable_out`=0, `mem_we_out`=0.
- `alu_result_out`=0.
REQ-013 The EBREAK instruction itself SHALL pass with `wb_enable_out`=0 and `mem_we_out`=0.
REQ-014 Bubble input (0x00000013, rd=0) SHALL produce `wb_enable_out`=0 and `df_ex_enable`=0.

Reset
REQ-015 While `reset`=1 at a clock edge, all registered outputs SHALL be 0, except `iw_out` which SHALL be 0x00000013; `halted` SHALL be 0.
REQ-016 Reset asserted mid-operation, including while halted, SHALL discard the in-flight instruction and clear `halted` at that edge.
REQ-017 `df_ex_*` SHALL remain combinational during reset; decode ignores them while reset is asserted.

Structure
REQ-018 Shared package `rv32i_pkg` SHALL hold:
- Opcode constants (LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, SYSTEM).
- NOP = 32'h00000013 and EBREAK = 32'h00100073.
- funct3 ALU encodings.
- An `alu_op_t` enum.
REQ-019 SHALL instantiate one combinational sub-module `rv32i_alu` (inputs a, b, alu_op_t; output result). Decode and pipeline registers SHALL reside in `ex_stage`.

Verification
REQ-020 ADDI x5,x0,-1 (iw 0xFFF00293) -> `df_ex_enable`=1, `df_ex_reg`=5, `df_ex_data`=0xFFFFFFFF same cycle; `alu_result_out`=0xFFFFFFFF and `wb_enable_out`=1 one edge later.
REQ-021 SUB/SRA/SLTU with rs1=0x80000000, rs2=0x00000001 -> respectively 0x7FFFFFFF, 0xC0000000, 0x0.
REQ-022 LW x6,8(x1), rs1=0x100 -> `alu_result_out`=0x108, `df_ex_enable`=0. SW with rs2=0xDEADBEEF, offset -4, rs1=0x100 -> `alu_result_out`=0xFC, `store_data_out`=0xDEADBEEF, `mem_we_out`=1.
REQ-023 JAL at pc_in=0x40 -> `alu_result_out`=0x44. AUIPC imm 0x1 at pc 0x40 -> `alu_result_out`=0x1040.
REQ-024 EBREAK followed by ADDI x7,x0,5 -> `ebreak_out`=1 and stays 1; the ADDI leaves as NOP with `wb_enable_out`=0; reset then clears `ebreak_out` at the next edge.
REQ-025 Reset asserted mid-stream -> after the edge, `iw_out`=0x00000013 and all other outputs are 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode, funct3 and ALU operation definitions
// Shared by the execute stage and its ALU.
// Contents:
//   - opcode constants
//   - NOP and EBREAK instruction words
//   - funct3 ALU encodings
//   - alu_op_t, plus a helper that maps funct3/funct7 to an ALU operation
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    // iw[30] selects SUB only for register-register ops.
    // For OP-IMM, iw[30] is part of the immediate except on right shifts.
    function automatic alu_op_t decode_alu_op(input logic [2:0] f3,
                                              input logic alt,
                                              input logic is_imm);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_alu.sv
// rtl/rv32i_alu.sv - combinational RV32I integer ALU
// Ports:
//   a, b   : 32-bit operands
//   op     : ALU operation
//   result : 32-bit result (wraparound arithmetic; shift amount is b[4:0])
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage with forwarding and sticky EBREAK halt
// Ports:
//   clk, reset                     : clock; synchronous active-high reset
//   pc_in .. ebreak_in             : instruction and operands from decode
//   df_ex_enable/reg/data          : combinational forwarding of this cycle's result
//   pc_out .. ebreak_out           : registered results to the memory stage
module ex_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [4:0]  wb_reg_in,
    input  logic        wb_enable_in,
    input  logic        mem_we_in,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic        ebreak_in,
    output logic        df_ex_enable,
    output logic [4:0]  df_ex_reg,
    output logic [31:0] df_ex_data,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_enable_out,
    output logic        mem_we_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic        ebreak_out
);

    logic [6:0]  opcode;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_op_t     alu_op;
    logic [31:0] alu_result;
    logic        halted;
    logic        rd_nonzero;

    assign opcode     = iw_in[6:0];
    assign imm_i      = {{20{iw_in[31]}}, iw_in[31:20]};
    assign imm_s      = {{20{iw_in[31]}}, iw_in[31:25], iw_in[11:7]};
    assign imm_u      = {iw_in[31:12], 12'b0};
    assign rd_nonzero = (wb_reg_in != 5'd0);

    // Every result goes through the adder or the ALU proper.
    // Opcodes that produce no value (branch, system, unknown) compute 0 + 0.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        case (opcode)
            OPC_LUI: begin
                alu_b = imm_u;
            end
            OPC_AUIPC: begin
                alu_a = pc_in;
                alu_b = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                alu_a = pc_in;
                alu_b = 32'd4;
            end
            OPC_LOAD: begin
                alu_a = rs1_data_in;
                alu_b = imm_i;
            end
            OPC_STORE: begin
                alu_a = rs1_data_in;
                alu_b = imm_s;
            end
            OPC_OP_IMM: begin
                alu_a  = rs1_data_in;
                alu_b  = imm_i;
                alu_op = decode_alu_op(iw_in[14:12], iw_in[30], 1'b1);
            end
            OPC_OP: begin
                alu_a  = rs1_data_in;
                alu_b  = rs2_data_in;
                alu_op = decode_alu_op(iw_in[14:12], iw_in[30], 1'b0);
            end
            default: ;
        endcase
    end

    rv32i_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    // A load's value is not known until the memory stage, so it is never forwarded from here.
    assign df_ex_data   = alu_result;
    assign df_ex_reg    = wb_reg_in;
    assign df_ex_enable = wb_enable_in && rd_nonzero && (opcode != OPC_LOAD) && !halted;

    assign ebreak_out = halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            halted         <= 1'b0;
            pc_out         <= '0;
            iw_out         <= NOP;
            wb_reg_out     <= '0;
            wb_enable_out  <= 1'b0;
            mem_we_out     <= 1'b0;
            alu_result_out <= '0;
            store_data_out <= '0;
        end else begin
            halted <= halted || ebreak_in;
            pc_out <= pc_in;
            if (halted) begin
                iw_out         <= NOP;
                wb_reg_out     <= '0;
                wb_enable_out  <= 1'b0;
                mem_we_out     <= 1'b0;
                alu_result_out <= '0;
                store_data_out <= '0;
            end else begin
                iw_out         <= iw_in;
                wb_reg_out     <= wb_reg_in;
                // The EBREAK itself flows on but must not write anything.
                wb_enable_out  <= wb_enable_in && rd_nonzero && !ebreak_in;
                mem_we_out     <= mem_we_in && !ebreak_in;
                alu_result_out <= alu_result;
                store_data_out <= rs2_data_in;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] iw_in;
    logic [4:0]  wb_reg_in;
    logic        wb_enable_in;
    logic        mem_we_in;
    logic [31:0] rs1_data_in;
    logic [31:0] rs2_data_in;
    logic        ebreak_in;
    logic        df_ex_enable;
    logic [4:0]  df_ex_reg;
    logic [31:0] df_ex_data;
    logic [31:0] pc_out;
    logic [31:0] iw_out;
    logic [4:0]  wb_reg_out;
    logic        wb_enable_out;
    logic        mem_we_out;
    logic [31:0] alu_result_out;
    logic [31:0] store_data_out;
    logic        ebreak_out;

    int tests = 0;
    int fails = 0;

    ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .iw_in          (iw_in),
        .wb_reg_in      (wb_reg_in),
        .wb_enable_in   (wb_enable_in),
        .mem_we_in      (mem_we_in),
        .rs1_data_in    (rs1_data_in),
        .rs2_data_in    (rs2_data_in),
        .ebreak_in      (ebreak_in),
        .df_ex_enable   (df_ex_enable),
        .df_ex_reg      (df_ex_reg),
        .df_ex_data     (df_ex_data),
        .pc_out         (pc_out),
        .iw_out         (iw_out),
        .wb_reg_out     (wb_reg_out),
        .wb_enable_out  (wb_enable_out),
        .mem_we_out     (mem_we_out),
        .alu_result_out (alu_result_out),
        .store_data_out (store_data_out),
        .ebreak_out     (ebreak_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] iw, input logic [4:0] rd,
                         input logic wen, input logic mwe, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic eb);
        pc_in        = pc;
        iw_in        = iw;
        wb_reg_in    = rd;
        wb_enable_in = wen;
        mem_we_in    = mwe;
        rs1_data_in  = rs1;
        rs2_data_in  = rs2;
        ebreak_in    = eb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h10, 32'hFFF0_0293, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("reset_iw", iw_out, 32'h0000_0013);
        chk("reset_pc", pc_out, 32'h0);
        chk("reset_alu", alu_result_out, 32'h0);
        chk("reset_wen", wb_enable_out, 32'h0);
        chk("reset_wreg", wb_reg_out, 32'h0);
        chk("reset_mwe", mem_we_out, 32'h0);
        chk("reset_sd", store_data_out, 32'h0);
        chk("reset_ebreak", ebreak_out, 32'h0);
        reset = 1'b0;

        // ADDI x5,x0,-1
        drive(32'h20, 32'hFFF0_0293, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("addi_df_en", df_ex_enable, 32'h1);
        chk("addi_df_reg", df_ex_reg, 32'h5);
        chk("addi_df_data", df_ex_data, 32'hFFFF_FFFF);
        tick();
        chk("addi_alu", alu_result_out, 32'hFFFF_FFFF);
        chk("addi_wen", wb_enable_out, 32'h1);
        chk("addi_wreg", wb_reg_out, 32'h5);
        chk("addi_pc", pc_out, 32'h20);
        chk("addi_iw", iw_out, 32'hFFF0_0293);

        // SUB / SRA / SLTU / SLT x3,x1,x2 with rs1=0x80000000, rs2=1
        drive(32'h24, 32'h4020_81B3, 5'd3, 1'b1, 1'b0, 32'h8000_0000, 32'h1, 1'b0);
        tick();
        chk("sub", alu_result_out, 32'h7FFF_FFFF);
        drive(32'h28, 32'h4020_D1B3, 5'd3, 1'b1, 1'b0, 32'h8000_0000, 32'h1, 1'b0);
        tick();
        chk("sra", alu_result_out, 32'hC000_0000);
        drive(32'h2C, 32'h0020_B1B3, 5'd3, 1'b1, 1'b0, 32'h8000_0000, 32'h1, 1'b0);
        tick();
        chk("sltu", alu_result_out, 32'h0);
        drive(32'h30, 32'h0020_A1B3, 5'd3, 1'b1, 1'b0, 32'h8000_0000, 32'h1, 1'b0);
        tick();
        chk("slt", alu_result_out, 32'h1);

        // LW x6,8(x1)
        drive(32'h34, 32'h0080_A303, 5'd6, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        chk("lw_df_en", df_ex_enable, 32'h0);
        tick();
        chk("lw_alu", alu_result_out, 32'h108);
        chk("lw_wen", wb_enable_out, 32'h1);

        // SW x2,-4(x1)
        drive(32'h38, 32'hFE20_AE23, 5'd0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("sw_alu", alu_result_out, 32'hFC);
        chk("sw_sd", store_data_out, 32'hDEAD_BEEF);
        chk("sw_mwe", mem_we_out, 32'h1);
        chk("sw_wen", wb_enable_out, 32'h0);

        // JAL x1,8 and AUIPC x4,1 at pc 0x40
        drive(32'h40, 32'h0080_00EF, 5'd1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("jal", alu_result_out, 32'h44);
        drive(32'h40, 32'h0000_1217, 5'd4, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("auipc", alu_result_out, 32'h1040);

        // Bubble with a write request to x0
        drive(32'h44, 32'h0000_0013, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("bubble_df_en", df_ex_enable, 32'h0);
        tick();
        chk("bubble_wen", wb_enable_out, 32'h0);

        // EBREAK then ADDI x7,x0,5
        drive(32'h48, 32'h0010_0073, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("ebreak_out", ebreak_out, 32'h1);
        chk("ebreak_iw", iw_out, 32'h0010_0073);
        chk("ebreak_wen", wb_enable_out, 32'h0);
        chk("ebreak_mwe", mem_we_out, 32'h0);
        drive(32'h4C, 32'h0050_0393, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("halt_df_en", df_ex_enable, 32'h0);
        tick();
        chk("halt_iw", iw_out, 32'h0000_0013);
        chk("halt_wen", wb_enable_out, 32'h0);
        chk("halt_alu", alu_result_out, 32'h0);
        chk("halt_sticky", ebreak_out, 32'h1);
        drive(32'h50, 32'hFE20_AE23, 5'd0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("halt_mwe", mem_we_out, 32'h0);
        chk("halt_sticky2", ebreak_out, 32'h1);

        // Reset while halted with an ADDI in flight
        reset = 1'b1;
        drive(32'h54, 32'h0050_0393, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("rst_halt_ebreak", ebreak_out, 32'h0);
        chk("rst_halt_iw", iw_out, 32'h0000_0013);
        chk("rst_halt_wen", wb_enable_out, 32'h0);
        chk("rst_halt_alu", alu_result_out, 32'h0);
        reset = 1'b0;

        // Pipeline running again after reset
        drive(32'h58, 32'h0050_0393, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("post_df_en", df_ex_enable, 32'h1);
        tick();
        chk("post_alu", alu_result_out, 32'h5);
        chk("post_wen", wb_enable_out, 32'h1);

        // Reset mid-stream with a store in flight
        drive(32'h5C, 32'hFE20_AE23, 5'd0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
        reset = 1'b1;
        #1;
        tick();
        chk("rst_mid_iw", iw_out, 32'h0000_0013);
        chk("rst_mid_pc", pc_out, 32'h0);
        chk("rst_mid_alu", alu_result_out, 32'h0);
        chk("rst_mid_sd", store_data_out, 32'h0);
        chk("rst_mid_mwe", mem_we_out, 32'h0);
        chk("rst_mid_wreg", wb_reg_out, 32'h0);
        chk("rst_mid_ebreak", ebreak_out, 32'h0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
